// File: rtl/get_pkg.sv
// Shared types and default widths for the get-path stream gate.
package get_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    DONE
  } get_state_t;

endpackage

// File: rtl/get_stream_gate_if.sv
// Host-side input stream plus core-side beat handshake of the get-path gate.
interface get_stream_gate_if #(
  parameter int unsigned DATA_W = 32
);

  logic              get_valid;
  logic [DATA_W-1:0] get_data;
  logic              get_last;
  logic              get_ready;
  logic              core_ready;
  logic              get_v;
  logic [DATA_W-1:0] get_d;

  // Environment side: drives the upstream beat and the core acceptance.
  modport master (
    output get_valid,
    output get_data,
    output get_last,
    output core_ready,
    input  get_ready,
    input  get_v,
    input  get_d
  );

  // Gate side.
  modport slave (
    input  get_valid,
    input  get_data,
    input  get_last,
    input  core_ready,
    output get_ready,
    output get_v,
    output get_d
  );

endinterface

// File: rtl/get_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a synchronous pointer clear.
module get_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      // Abort: contents are left in place but become unreachable.
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q[AW-1:0]] <= din;
        wr_q              <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
    end
  end

  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign dout  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/get_stream_gate.sv
// Get-path gate: admits a counted host stream while run & ~gen, buffers it, and
// presents it to the core; flags get_last misplacement.
module get_stream_gate
  import get_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             gen,
  input  logic [CNT_W-1:0] len,
  get_stream_gate_if.slave bus,
  output logic [CNT_W-1:0] get_cnt,
  output logic             get_done,
  output logic             last_err
);

  get_state_t       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             final_beat;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic             clr;
  logic             active;

  assign active     = (state_q == RECV) || (state_q == FLUSH);
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign final_beat = (cnt_inc == len_q);

  // Upstream ready never depends on core_ready.
  assign bus.get_ready = (state_q == RECV) & ~full & run & ~gen;
  assign bus.get_v     = ~empty & ~gen & active;
  assign accept        = bus.get_valid & bus.get_ready;
  assign pop           = bus.get_v & bus.core_ready;

  get_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (accept),
    .din   (bus.get_data),
    .pop   (pop),
    .dout  (bus.get_d),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    clr     = 1'b0;

    if (accept) begin
      cnt_d = cnt_inc;
      // Marker must appear on exactly the final beat.
      if (bus.get_last != final_beat) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (run && !gen) begin
          cnt_d = '0;
          if (len != '0) begin
            state_d = RECV;
            len_d   = len;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RECV: begin
        if (accept && final_beat) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (empty && !gen) begin
          state_d = DONE;
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    // Abort from any busy state; count is kept for software to inspect.
    if (!run && state_q != IDLE) begin
      state_d = IDLE;
      clr     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign get_cnt  = cnt_q;
  assign get_done = (state_q == DONE);
  assign last_err = err_q;

endmodule
